// File: rtl/svc_axil_wr_arbiter.sv
// Shares one AXI-Lite write manager port among NUM_M requesters, one transaction at a time.
// Define SVC_AXIL_WR_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module svc_axil_wr_arbiter #(
    parameter int NUM_M          = 2,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_M-1:0]                    s_axil_awvalid,
    input  logic [NUM_M*AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
    output logic [NUM_M-1:0]                    s_axil_awready,
    input  logic [NUM_M-1:0]                    s_axil_wvalid,
    input  logic [NUM_M*AXI_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [NUM_M*AXI_STRB_WIDTH-1:0]     s_axil_wstrb,
    output logic [NUM_M-1:0]                    s_axil_wready,
    output logic [NUM_M-1:0]                    s_axil_bvalid,
    output logic [NUM_M*2-1:0]                  s_axil_bresp,
    input  logic [NUM_M-1:0]                    s_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]           m_axil_awaddr,
    output logic                                m_axil_awvalid,
    input  logic                                m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]           m_axil_wdata,
    output logic [AXI_STRB_WIDTH-1:0]           m_axil_wstrb,
    output logic                                m_axil_wvalid,
    input  logic                                m_axil_wready,
    input  logic [1:0]                          m_axil_bresp,
    input  logic                                m_axil_bvalid,
    output logic                                m_axil_bready,
    output logic                                busy
);
    localparam int IDX_W = $clog2(NUM_M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0] grant_idx_r, grant_idx_nxt_s, winner_s;
    logic             aw_done_r, aw_done_nxt_s, w_done_r, w_done_nxt_s;
    logic             any_req_s;

    assign any_req_s = |s_axil_awvalid;

`ifdef SVC_AXIL_WR_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] cand_s;
    int               cand_int_s;

    // Rotating search from rr_ptr; scanning offsets downward lets the nearest requester win.
    always_comb begin
        winner_s   = {IDX_W{1'b0}};
        cand_int_s = 0;
        cand_s     = {IDX_W{1'b0}};
        for (int k = NUM_M - 1; k >= 0; k--) begin
            cand_int_s = int'(rr_ptr_r) + k;
            if (cand_int_s >= NUM_M) begin
                cand_int_s = cand_int_s - NUM_M;
            end else begin
                cand_int_s = cand_int_s;
            end
            cand_s = IDX_W'(cand_int_s);
            if (s_axil_awvalid[cand_s]) begin
                winner_s = cand_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Round-robin pointer advances past each new winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (state_r == IDLE && any_req_s) begin
            if (winner_s == IDX_W'(NUM_M - 1)) begin
                rr_ptr_r <= {IDX_W{1'b0}};
            end else begin
                rr_ptr_r <= winner_s + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    // Fixed priority: lowest-index awvalid wins.
    always_comb begin
        winner_s = {IDX_W{1'b0}};
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (s_axil_awvalid[k]) begin
                winner_s = IDX_W'(k);
            end else begin
                winner_s = winner_s;
            end
        end
    end
`endif

    // Data paths follow the grant in every state; only the valids are gated.
    assign m_axil_awaddr = s_axil_awaddr[grant_idx_r*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign m_axil_wdata  = s_axil_wdata[grant_idx_r*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign m_axil_wstrb  = s_axil_wstrb[grant_idx_r*AXI_STRB_WIDTH +: AXI_STRB_WIDTH];
    assign busy          = (state_r != IDLE);

    // Next-state logic and handshake routing for the granted requester.
    always_comb begin
        state_nxt_s     = state_r;
        grant_idx_nxt_s = grant_idx_r;
        aw_done_nxt_s   = aw_done_r;
        w_done_nxt_s    = w_done_r;
        s_axil_awready  = {NUM_M{1'b0}};
        s_axil_wready   = {NUM_M{1'b0}};
        s_axil_bvalid   = {NUM_M{1'b0}};
        s_axil_bresp    = {(NUM_M*2){1'b0}};
        m_axil_awvalid  = 1'b0;
        m_axil_wvalid   = 1'b0;
        m_axil_bready   = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s     = XFER;
                    grant_idx_nxt_s = winner_s;
                    aw_done_nxt_s   = 1'b0;
                    w_done_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XFER: begin
                m_axil_awvalid             = s_axil_awvalid[grant_idx_r] & ~aw_done_r;
                s_axil_awready[grant_idx_r] = m_axil_awready & ~aw_done_r;
                m_axil_wvalid              = s_axil_wvalid[grant_idx_r] & ~w_done_r;
                s_axil_wready[grant_idx_r]  = m_axil_wready & ~w_done_r;
                aw_done_nxt_s = aw_done_r | (m_axil_awvalid & m_axil_awready);
                w_done_nxt_s  = w_done_r | (m_axil_wvalid & m_axil_wready);
                if (aw_done_nxt_s && w_done_nxt_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            RESP: begin
                s_axil_bvalid[grant_idx_r]         = m_axil_bvalid;
                s_axil_bresp[grant_idx_r*2 +: 2]   = m_axil_bresp;
                m_axil_bready                      = s_axil_bready[grant_idx_r];
                if (m_axil_bvalid && s_axil_bready[grant_idx_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, grant and handshake-progress registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            grant_idx_r <= {IDX_W{1'b0}};
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_idx_r <= grant_idx_nxt_s;
            aw_done_r   <= aw_done_nxt_s;
            w_done_r    <= w_done_nxt_s;
        end
    end
endmodule

// File: tb/tb_svc_axil_wr_arbiter.sv
// Self-checking bench for svc_axil_wr_arbiter: cycle-by-cycle vector table plus a contention sequence.
module tb_svc_axil_wr_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  s_axil_awvalid;
    logic [15:0] s_axil_awaddr;
    logic [1:0]  s_axil_awready;
    logic [1:0]  s_axil_wvalid;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic [1:0]  s_axil_wready;
    logic [1:0]  s_axil_bvalid;
    logic [3:0]  s_axil_bresp;
    logic [1:0]  s_axil_bready;
    logic [7:0]  m_axil_awaddr;
    logic        m_axil_awvalid;
    logic        m_axil_awready;
    logic [15:0] m_axil_wdata;
    logic [1:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid;
    logic        m_axil_bready;
    logic        busy;

    svc_axil_wr_arbiter #(
        .NUM_M(2), .AXI_ADDR_WIDTH(8), .AXI_DATA_WIDTH(16), .AXI_STRB_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr), .s_axil_awready(s_axil_awready),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wready(s_axil_wready), .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp),
        .s_axil_bready(s_axil_bready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  awv, wv, bry;
        logic        mawr, mwr, mbv;
        logic [1:0]  mbr;
        logic [1:0]  chk;     // bit0: control outputs, bit1: muxed data
        logic [13:0] ectl;
        logic [25:0] edat;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [13:0] Z  = 14'h0000;
    localparam logic [25:0] D1 = {8'h40, 16'hBEEF, 2'b11};
    localparam logic [25:0] D0 = {8'h12, 16'h1234, 2'b01};

    // Packs {s_awready, s_wready, s_bvalid, s_bresp, m_awvalid, m_wvalid, m_bready, busy}.
    function automatic logic [13:0] cv(input logic [1:0] awr, input logic [1:0] wr, input logic [1:0] bv,
                                       input logic [3:0] br, input logic mawv, input logic mwv,
                                       input logic mbry, input logic bsy);
        return {awr, wr, bv, br, mawv, mwv, mbry, bsy};
    endfunction

    task automatic add(input string nm, input logic r, input logic [1:0] awv, input logic [1:0] wv,
                       input logic [1:0] bry, input logic mawr, input logic mwr, input logic mbv,
                       input logic [1:0] mbr, input logic [1:0] chk, input logic [13:0] ectl,
                       input logic [25:0] edat);
        vec_t v;
        v.name = nm; v.rst = r; v.awv = awv; v.wv = wv; v.bry = bry;
        v.mawr = mawr; v.mwr = mwr; v.mbv = mbv; v.mbr = mbr;
        v.chk = chk; v.ectl = ectl; v.edat = edat;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int          cnt [2];
    int          gidx[$];
    int          gcyc[$];
    int          cyc;
    logic [13:0] act_ctl;
    logic [25:0] act_dat;
    logic [7:0]  exp_addr;
    int          exp_g;

    initial begin
        rst = 1'b1;
        s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00; s_axil_bready = 2'b00;
        s_axil_awaddr  = {8'h40, 8'h12};
        s_axil_wdata   = {16'hBEEF, 16'h1234};
        s_axil_wstrb   = {2'b11, 2'b01};
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;

        for (int i = 0; i < 10; i++)
            add("idle", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, Z, D0);
        // Single write from requester 1
        add("wr1_idle", 1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, Z, D1);
        add("wr1_xfer", 1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11,
            cv(2'b10, 2'b10, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1), D1);
        add("wr1_resp", 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 2'b01,
            cv(2'b00, 2'b00, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1), D1);
        add("wr1_done", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, Z, D1);
        // Split: W accepted three cycles before AW
        add("spl_idle", 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, Z, D0);
        add("spl_w",    1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11,
            cv(2'b00, 2'b01, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1), D0);
        for (int i = 0; i < 2; i++)
            add("spl_wait", 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01,
                cv(2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1), D0);
        add("spl_aw",   1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01,
            cv(2'b01, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1), D0);
        add("spl_resp", 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01,
            cv(2'b00, 2'b00, 2'b01, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1), D0);
        add("spl_done", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, Z, D0);
        // B backpressure for five cycles
        add("bp_idle", 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, Z, D0);
        add("bp_xfer", 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01,
            cv(2'b01, 2'b01, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1), D0);
        for (int i = 0; i < 5; i++)
            add("bp_hold", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01,
                cv(2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1), D0);
        add("bp_accept", 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01,
            cv(2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1), D0);
        add("bp_done", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, Z, D0);
        // Reset after AW, before W
        add("rx_idle", 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, Z, D1);
        add("rx_aw",   1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11,
            cv(2'b10, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1), D1);
        add("rx_wwait", 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01,
            cv(2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1), D1);
        add("rx_rst",  1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, Z, D1);
        add("rx_after", 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, Z, D0);
        add("rx_xfer", 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11,
            cv(2'b01, 2'b01, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1), D0);
        add("rx_resp", 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01,
            cv(2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1), D0);
        add("rx_done", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, Z, D0);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            s_axil_awvalid = vecs[i].awv; s_axil_wvalid = vecs[i].wv; s_axil_bready = vecs[i].bry;
            m_axil_awready = vecs[i].mawr; m_axil_wready = vecs[i].mwr;
            m_axil_bvalid = vecs[i].mbv; m_axil_bresp = vecs[i].mbr;
            #1;
            act_ctl = {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
                       m_axil_awvalid, m_axil_wvalid, m_axil_bready, busy};
            act_dat = {m_axil_awaddr, m_axil_wdata, m_axil_wstrb};
            if (vecs[i].chk[0]) check({vecs[i].name, "_ctl"}, 32'(act_ctl), 32'(vecs[i].ectl));
            if (vecs[i].chk[1]) check({vecs[i].name, "_dat"}, 32'(act_dat), 32'(vecs[i].edat));
        end

        // Contention: both requesters keep requesting until each has four completed writes.
        @(negedge clk);
        rst = 1'b1;
        s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00;
        s_axil_awaddr = {8'hA1, 8'hA0};
        repeat (2) @(posedge clk);
        cnt[0] = 0; cnt[1] = 0; cyc = 0;
        while ((cnt[0] < 4 || cnt[1] < 4) && cyc < 80) begin
            @(negedge clk);
            rst = 1'b0;
            cyc++;
            s_axil_awvalid = {cnt[1] < 4, cnt[0] < 4};
            s_axil_wvalid  = {cnt[1] < 4, cnt[0] < 4};
            s_axil_bready  = 2'b11;
            m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
            #1;
            if (s_axil_awready != 2'b00) begin
                gidx.push_back(s_axil_awready[1] ? 1 : 0);
                gcyc.push_back(cyc);
                exp_addr = s_axil_awready[1] ? 8'hA1 : 8'hA0;
                check("cont_addr", 32'(m_axil_awaddr), 32'(exp_addr));
            end
            if (s_axil_bvalid[0]) cnt[0]++;
            if (s_axil_bvalid[1]) cnt[1]++;
        end
        check("cont_grants", 32'(gidx.size()), 32'd8);
        for (int k = 0; k < gidx.size(); k++) begin
`ifdef SVC_AXIL_WR_ARB_RR_EN
            exp_g = k % 2;
`else
            exp_g = (k >= 4) ? 1 : 0;
`endif
            check("cont_order", 32'(gidx[k]), 32'(exp_g));
            if (k > 0) check("cont_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        end

        @(negedge clk);
        s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00; m_axil_bvalid = 1'b0;
        #1;
        check("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
